// File: rtl/eater_pkg.sv
// eater_pkg: loader FSM states and default timing constants shared by the program loader.
package eater_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_BYTE, SETUP, WRITE, HOLD, FINISH} state_e;
    localparam int DEF_NUM_WORDS    = 16;
    localparam int DEF_SETUP_CYCLES = 2;
    localparam int DEF_WR_CYCLES    = 1;
    localparam int DEF_HOLD_CYCLES  = 2;
    localparam int TMR_W            = 8;
endpackage

// File: rtl/prog_loader_phase_timer.sv
// phase_timer: loadable down-counter; expire is high in the last cycle of a loaded interval.
module phase_timer
    import eater_pkg::*;
(
    input  logic             fastClk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expire
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);

    always_ff @(posedge fastClk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = cnt_q == TMR_W'(1);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams bytes into RAM addresses 0..NUM_WORDS-1 with timed setup/strobe/hold phases.
module prog_loader
    import eater_pkg::*;
#(
    parameter int NUM_WORDS    = DEF_NUM_WORDS,
    parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
    parameter int WR_CYCLES    = DEF_WR_CYCLES,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
    input  logic       fastClk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       prog_mode,
    output logic [3:0] addr,
    output logic [7:0] data,
    output logic       wr_en,
    output logic       busy,
    output logic       done
);
    localparam logic [3:0] LAST_ADDR = 4'(NUM_WORDS - 1);

    state_e           state_q, state_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             in_ready_q, in_ready_d, prog_mode_q, prog_mode_d;
    logic             wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
    logic             tmr_load, tmr_expire;
    logic [TMR_W-1:0] tmr_val;

    phase_timer u_timer (
        .fastClk (fastClk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .expire  (tmr_expire)
    );

    // Timer is loaded on the edge that enters each timed phase; abort wins over every transition.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d = WAIT_BYTE;
                addr_d  = '0;
            end
            WAIT_BYTE: if (abort) state_d = IDLE;
            else if (in_valid && in_ready_q) begin
                data_d   = in_data;
                state_d  = SETUP;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(SETUP_CYCLES);
            end
            SETUP: if (abort) state_d = IDLE;
            else if (tmr_expire) begin
                state_d  = WRITE;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(WR_CYCLES);
            end
            WRITE: if (abort) state_d = IDLE;
            else if (tmr_expire) begin
                state_d  = HOLD;
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(HOLD_CYCLES);
            end
            HOLD: if (abort) state_d = IDLE;
            else if (tmr_expire) begin
                if (addr_q == LAST_ADDR) state_d = FINISH;
                else begin
                    state_d = WAIT_BYTE;
                    addr_d  = addr_q + 4'd1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == WAIT_BYTE;
        wr_en_d     = state_d == WRITE;
        prog_mode_d = state_d inside {WAIT_BYTE, SETUP, WRITE, HOLD};
        busy_d      = state_d != IDLE;
        done_d      = state_d == FINISH;
    end

    always_ff @(posedge fastClk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b0;
            prog_mode_q <= 1'b0;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            prog_mode_q <= prog_mode_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign prog_mode = prog_mode_q;
    assign addr      = addr_q;
    assign data      = data_q;
    assign wr_en     = wr_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench; a default loader plus a short-word, wide-strobe loader.
module tb_prog_loader;
    localparam int S = 2, W = 1, H = 2;
    localparam int SB = 1, WB = 3, HB = 1;

    logic       fastClk = 0, rst = 1;
    logic       start_a = 0, abort_a = 0, in_valid_a = 0;
    logic [7:0] in_data_a = 0;
    logic       in_ready_a, prog_mode_a, wr_en_a, busy_a, done_a;
    logic [3:0] addr_a;
    logic [7:0] data_a;
    logic       start_b = 0, abort_b = 0, in_valid_b = 0;
    logic [7:0] in_data_b = 0;
    logic       in_ready_b, prog_mode_b, wr_en_b, busy_b, done_b;
    logic [3:0] addr_b;
    logic [7:0] data_b;

    int total_cnt = 0, pass_cnt = 0, cyc = 0, acc_cyc = 0, done_cnt = 0, start_cyc = 0, exp_addr = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_b_q[$];
    bit killed = 0;

    prog_loader dut_a (
        .fastClk(fastClk), .rst(rst), .start(start_a), .abort(abort_a), .in_valid(in_valid_a),
        .in_data(in_data_a), .in_ready(in_ready_a), .prog_mode(prog_mode_a), .addr(addr_a),
        .data(data_a), .wr_en(wr_en_a), .busy(busy_a), .done(done_a)
    );

    prog_loader #(.NUM_WORDS(2), .SETUP_CYCLES(SB), .WR_CYCLES(WB), .HOLD_CYCLES(HB)) dut_b (
        .fastClk(fastClk), .rst(rst), .start(start_b), .abort(abort_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .prog_mode(prog_mode_b), .addr(addr_b),
        .data(data_b), .wr_en(wr_en_b), .busy(busy_b), .done(done_b)
    );

    always #5 fastClk = ~fastClk;
    always @(posedge fastClk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor A: each word (prog_mode with in_ready low) must match the next queued {addr,data}.
    logic [11:0] cur, bad_val;
    bit have_cur = 0, word_bad = 0, prev_wr = 0;
    int wr_start = 0, wr_end = 0, pulses = 0;
    always @(negedge fastClk) begin
        if (!rst) begin
            if (in_ready_a) check("in_ready_only_wait", 32'({wr_en_a, prog_mode_a, done_a}), 32'b010);
            if (done_a) begin
                done_cnt++;
                check("done_prog_mode_low", 32'(prog_mode_a), 0);
            end
            if (prog_mode_a && !in_ready_a) begin
                if (!have_cur) begin
                    if (exp_q.size() == 0) check("word_expected", 32'(exp_q.size()), 1);
                    else begin
                        cur = exp_q.pop_front();
                        have_cur = 1; word_bad = 0; pulses = 0;
                    end
                end
                if (have_cur && !word_bad && {addr_a, data_a} !== cur) begin
                    word_bad = 1;
                    bad_val = {addr_a, data_a};
                end
                if (wr_en_a && !prev_wr) begin
                    pulses++;
                    wr_start = cyc;
                    check("setup_len", 32'(cyc - acc_cyc), 32'(1 + S));
                end
                if (!wr_en_a && prev_wr) begin
                    wr_end = cyc;
                    check("wr_width", 32'(cyc - wr_start), 32'(W));
                end
            end else if (have_cur) begin
                have_cur = 0;
                if (!killed) begin
                    check("word_addr_data", 32'(word_bad ? bad_val : cur), 32'(cur));
                    check("wr_pulses", 32'(pulses), 1);
                    check("hold_len", 32'(cyc - wr_end), 32'(H));
                end
            end
        end
        prev_wr = wr_en_a;
    end

    // Monitor B: each completed strobe is compared with the queued write and its width.
    bit prev_wr_b = 0;
    int wb_start = 0;
    logic [11:0] wb_ad, eb;
    always @(negedge fastClk) begin
        if (!rst) begin
            if (wr_en_b && !prev_wr_b) begin
                wb_start = cyc;
                wb_ad = {addr_b, data_b};
            end
            if (!wr_en_b && prev_wr_b) begin
                if (exp_b_q.size() == 0) check("b_write_expected", 32'(exp_b_q.size()), 1);
                else begin
                    eb = exp_b_q.pop_front();
                    check("b_addr_data", 32'(wb_ad), 32'(eb));
                    check("b_wr_width", 32'(cyc - wb_start), 32'(WB));
                end
            end
        end
        prev_wr_b = wr_en_b;
    end

    task automatic check_idle_a(string name);
        check(name, 32'({in_ready_a, prog_mode_a, wr_en_a, busy_a, done_a, addr_a, data_a}), 0);
    endtask

    task automatic start_load();
        exp_addr = 0;
        killed = 0;
        start_a = 1;
        start_cyc = cyc;
        @(negedge fastClk);
        start_a = 0;
        check("start_state", 32'({prog_mode_a, busy_a, in_ready_a, addr_a}), 32'b111_0000);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        while (!in_ready_a && t < 100) begin
            @(negedge fastClk);
            t++;
        end
        if (!in_ready_a) begin
            check("in_ready_timeout", 32'(in_ready_a), 1);
            return;
        end
        repeat (gap) @(negedge fastClk);
        in_valid_a = 1;
        in_data_a = b;
        acc_cyc = cyc;
        exp_q.push_back({4'(exp_addr), b});
        exp_addr++;
        @(negedge fastClk);
        in_valid_a = 0;
        in_data_a = 8'($urandom);
    endtask

    task automatic wait_done(output int at);
        int t = 0;
        while (!done_a && t < 300) begin
            @(negedge fastClk);
            t++;
        end
        check("done_seen", 32'(done_a), 1);
        at = cyc;
        @(negedge fastClk);
        check("done_one_cycle", 32'({done_a, busy_a, prog_mode_a}), 0);
    endtask

    task automatic wait_wr(input logic [3:0] a);
        int t = 0;
        while (!(wr_en_a && addr_a == a) && t < 100) begin
            @(negedge fastClk);
            t++;
        end
        check("wr_reached", 32'({wr_en_a, addr_a}), 32'({1'b1, a}));
    endtask

    initial begin
        int at, t, d0;
        start_a = 1; in_valid_a = 1; abort_a = 1;
        repeat (3) @(negedge fastClk);
        check_idle_a("reset_outputs_a");
        check("reset_outputs_b", 32'({in_ready_b, prog_mode_b, wr_en_b, busy_b, done_b, addr_b, data_b}), 0);
        rst = 0; start_a = 0; in_valid_a = 0; abort_a = 0;
        repeat (2) @(negedge fastClk);

        start_load();
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        wait_done(at);
        check("done_cycle", 32'(at - start_cyc), 97);
        check("queue_drained", 32'(exp_q.size()), 0);

        start_load();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 3);
        wait_done(at);

        start_load();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), int'($urandom_range(0, 2)));
        wait_wr(4'd5);
        killed = 1;
        abort_a = 1;
        @(negedge fastClk);
        abort_a = 0;
        check("abort_outputs", 32'({wr_en_a, prog_mode_a, busy_a, done_a}), 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (10) @(negedge fastClk);
        check("no_done_after_abort", 32'(done_cnt), 32'(d0));
        start_load();
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), int'($urandom_range(0, 1)));
        wait_done(at);

        start_load();
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
        wait_wr(4'd9);
        t = 0;
        while (wr_en_a && t < 20) begin
            @(negedge fastClk);
            t++;
        end
        killed = 1;
        rst = 1;
        in_valid_a = 1;
        start_a = 1;
        @(negedge fastClk);
        check_idle_a("rst_mid_hold");
        rst = 0;
        start_a = 0;
        exp_q.delete();
        repeat (5) @(negedge fastClk);
        check("in_ready_after_rst", 32'({in_ready_a, busy_a, prog_mode_a}), 0);
        in_valid_a = 0;

        start_load();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0);
        start_a = 1;
        @(negedge fastClk);
        start_a = 0;
        for (int i = 4; i < 16; i++) send_byte(8'($urandom), 0);
        wait_done(at);
        check("done_cycle_start_ignored", 32'(at - start_cyc), 97);

        start_a = 1;
        abort_a = 1;
        @(negedge fastClk);
        start_a = 0;
        abort_a = 0;
        check("start_abort_idle", 32'({busy_a, prog_mode_a, in_ready_a}), 0);

        d0 = cyc;
        start_b = 1;
        @(negedge fastClk);
        start_b = 0;
        in_valid_b = 1;
        in_data_b = 8'($urandom);
        exp_b_q.push_back({4'd0, in_data_b});
        check("b_in_ready_first", 32'(in_ready_b), 1);
        @(negedge fastClk);
        in_data_b = 8'($urandom);
        exp_b_q.push_back({4'd1, in_data_b});
        t = 0;
        while (!done_b && t < 100) begin
            @(negedge fastClk);
            check("b_addr_bound", 32'(addr_b <= 4'd1), 1);
            t++;
        end
        check("b_done", 32'({done_b, prog_mode_b}), 32'b10);
        check("b_done_cycle", 32'(cyc - d0), 32'(1 + 2 * (1 + SB + WB + HB)));
        check("b_all_written", 32'(exp_b_q.size()), 0);
        in_valid_b = 0;
        @(negedge fastClk);
        check("b_idle_after", 32'({busy_b, in_ready_b, done_b}), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
